// File: rtl/slave_mem_port.sv
// slave_mem_port
//   Local memory port behind the bus slave controller. A write strobe or
//   read request is accepted in IDLE, held for WAIT_CYCLES cycles, then
//   performed on an internal synchronous RAM. Completion is signalled by a
//   one-cycle module_dv pulse (with rd_data valid for reads).
//
// Ports
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   write_en   write strobe from the slave
//   read_req   read request from the slave
//   addr       word address (ADDRESS_WIDTH)
//   wr_data    write data (DATA_WIDTH)
//   rd_data    read data, valid with module_dv and held afterwards
//   module_dv  one-cycle completion pulse per accepted request
//   busy       high from acceptance until completion
//   addr_err   accepted request addressed beyond MEM_DEPTH
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | waiting for write_en / read_req
// S_WAIT   | counting emulated access latency
// S_ACCESS | RAM operation, raise module_dv
// S_DONE   | module_dv visible; drop busy next edge

module slave_mem_port #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 4096,
    parameter int WAIT_CYCLES   = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     write_en,
    input  logic                     read_req,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     module_dv,
    output logic                     busy,
    output logic                     addr_err
);

    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so MEM_DEPTH == 2**ADDRESS_WIDTH is still representable.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_V   = (ADDRESS_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]             WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [IW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_write;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_write  <= 1'b0;
            rd_data   <= '0;
            module_dv <= 1'b0;
            busy      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (write_en || read_req) begin
                        addr_q   <= addr[IW-1:0];
                        data_q   <= wr_data;
                        // A simultaneous read is dropped in favour of the write.
                        op_write <= write_en;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        addr_err <= ({1'b0, addr} >= DEPTH_V);
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == WAIT_LAST) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!op_write) begin
                        rd_data <= addr_err ? '0 : mem[addr_q];
                    end
                    module_dv <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    module_dv <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset in ACCESS blocks the pending write.
    always_ff @(posedge clk) begin
        if (rstn && (state == S_ACCESS) && op_write && !addr_err) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_slave_mem_port.sv
module tb_slave_mem_port;

    logic        clk = 1'b0;
    logic        rstn;

    logic        we_a, rr_a, we_b, rr_b;
    logic [14:0] addr_a, addr_b;
    logic [7:0]  wd_a, wd_b;
    logic [7:0]  rd_a, rd_b;
    logic        dv_a, dv_b, busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slave_mem_port #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .MEM_DEPTH(4096), .WAIT_CYCLES(3)) dut_a (
        .clk(clk), .rstn(rstn), .write_en(we_a), .read_req(rr_a), .addr(addr_a),
        .wr_data(wd_a), .rd_data(rd_a), .module_dv(dv_a), .busy(busy_a), .addr_err(err_a)
    );

    slave_mem_port #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .MEM_DEPTH(4096), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rstn(rstn), .write_en(we_b), .read_req(rr_b), .addr(addr_b),
        .wr_data(wd_b), .rd_data(rd_b), .module_dv(dv_b), .busy(busy_b), .addr_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic we, input logic rr,
                         input logic [14:0] a, input logic [7:0] d);
        if (sel) begin
            we_b = we; rr_b = rr; addr_b = a; wd_b = d;
        end else begin
            we_a = we; rr_a = rr; addr_a = a; wd_a = d;
        end
    endtask

    function automatic logic get_dv(input bit sel);
        return sel ? dv_b : dv_a;
    endfunction

    // One full transaction. Inputs are scrambled right after acceptance to
    // show the latched values are used. Checks every cycle up to completion.
    task automatic xact(input string tag, input bit sel, input int w,
                        input logic we, input logic rr,
                        input logic [14:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err,
                        input bit extra_rr);
        int pulses;
        pulses = 0;
        @(negedge clk);
        drive(sel, we, rr, a, d);
        @(posedge clk);                        // E0
        @(negedge clk);
        drive(sel, 1'b0, extra_rr, ~a, ~d);
        chk({tag, ".busy_e0"}, sel ? busy_b : busy_a, 1);
        chk({tag, ".dv_e0"}, get_dv(sel), 0);
        for (int k = 1; k <= w + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, ~a, ~d);
            if (get_dv(sel)) pulses++;
            if (k == w + 1) begin
                chk({tag, ".dv"}, get_dv(sel), 1);
                chk({tag, ".rd"}, sel ? rd_b : rd_a, exp_rd);
                chk({tag, ".err"}, sel ? err_b : err_a, exp_err);
            end else begin
                chk({tag, ".dv_lo"}, get_dv(sel), 0);
            end
            chk({tag, ".busy"}, sel ? busy_b : busy_a, (k < w + 2) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_dv(sel)) pulses++;
        end
        chk({tag, ".pulses"}, pulses, 1);
        chk({tag, ".rd_hold"}, sel ? rd_b : rd_a, exp_rd);
    endtask

    initial begin
        int pulses;
        rstn = 1'b0;
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 1'($urandom), 1'($urandom), 15'($urandom), 8'($urandom));
            drive(1, 1'($urandom), 1'($urandom), 15'($urandom), 8'($urandom));
            @(posedge clk);
        end
        @(negedge clk);
        chk("rst.rd_a", rd_a, 0);
        chk("rst.dv_a", dv_a, 0);
        chk("rst.busy_a", busy_a, 0);
        chk("rst.err_a", err_a, 0);
        chk("rst.rd_b", rd_b, 0);
        chk("rst.dv_b", dv_b, 0);
        chk("rst.busy_b", busy_b, 0);
        chk("rst.err_b", err_b, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rstn = 1'b1;

        // WAIT_CYCLES=3: write then read back.
        xact("a_wr010", 0, 3, 1, 0, 15'h010, 8'h5A, 8'h00, 0, 0);
        xact("a_rd010", 0, 3, 0, 1, 15'h010, 8'h00, 8'h5A, 0, 0);

        // WAIT_CYCLES=0: top in-range word, then out-of-range aliasing check.
        xact("b_wrFFF", 1, 0, 1, 0, 15'h0FFF, 8'hC3, 8'h00, 0, 0);
        xact("b_rdFFF", 1, 0, 0, 1, 15'h0FFF, 8'h00, 8'hC3, 0, 0);
        xact("b_rd7FFF", 1, 0, 0, 1, 15'h7FFF, 8'h00, 8'h00, 1, 0);
        xact("b_wr7FFF", 1, 0, 1, 0, 15'h7FFF, 8'hEE, 8'h00, 1, 0);
        xact("b_rdFFF2", 1, 0, 0, 1, 15'h0FFF, 8'h00, 8'hC3, 0, 0);

        // Simultaneous write+read is a write; extra read during WAIT ignored.
        xact("a_both020", 0, 3, 1, 1, 15'h020, 8'h11, 8'h5A, 0, 0);
        xact("a_rd020", 0, 3, 0, 1, 15'h020, 8'h00, 8'h11, 0, 0);
        xact("a_rd010x", 0, 3, 0, 1, 15'h010, 8'h00, 8'h5A, 0, 1);

        // Reset in WAIT abandons the write to 0x030.
        xact("a_wr030", 0, 3, 1, 0, 15'h030, 8'h11, 8'h5A, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 15'h030, 8'h77);
        @(posedge clk);                        // E0
        @(negedge clk);
        drive(0, 0, 0, 15'h000, 8'h00);
        @(posedge clk);                        // E1
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);                        // E2 samples reset
        @(negedge clk);
        chk("mrst.busy", busy_a, 0);
        chk("mrst.dv", dv_a, 0);
        chk("mrst.rd", rd_a, 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dv_a) pulses++;
        end
        chk("mrst.no_dv", pulses, 0);
        chk("mrst.busy_after", busy_a, 0);
        xact("a_rd030", 0, 3, 0, 1, 15'h030, 8'h00, 8'h11, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_mem_port.md
# slave_mem_port

Local memory port that sits directly downstream of the bus slave controller. It accepts the slave's single-cycle write strobe or read request, together with the latched address and data. After a programmable wait it performs the access on an internal synchronous RAM, then returns a one-cycle `module_dv` completion pulse and, for reads, the read data. This pulse is what releases the slave from its busy-write and busy-read states.

## Interface
- `ADDRESS_WIDTH`, default 15: width of the `addr` input. Matches the slave's address buffer.
- `DATA_WIDTH`, default 8: memory word width.
- `MEM_DEPTH`, default 4096: number of RAM words. Must be a power of 2 and no greater than 2^ADDRESS_WIDTH.
- `WAIT_CYCLES`, default 3: emulated access latency. Legal range 0..15.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `write_en`  in  1  write strobe from the slave. Nominally a 1-cycle pulse.
- `read_req`  in  1  read request from the slave. Nominally a 1-cycle pulse.
- `addr`  in  ADDRESS_WIDTH  word address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_data`  out  DATA_WIDTH  read data. Valid while `module_dv` is high, and held afterwards.
- `module_dv`  out  1  completion pulse, exactly 1 cycle per accepted request.
- `busy`  out  1  high from request acceptance to completion.
- `addr_err`  out  1  set when the accepted request had `addr` ≥ MEM_DEPTH. Held until the next accepted request.

## Operation
- States:
  - IDLE: accept requests.
  - WAIT: count latency.
  - ACCESS: perform the RAM operation.
  - DONE: completion pulse visible.
- IDLE:
  - On `write_en` or `read_req`, latch `addr`, `wr_data` and the operation type.
  - Set `busy`=1 and clear the counter.
  - Compute `addr_err` = (addr ≥ MEM_DEPTH).
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- IDLE, simultaneous `write_en` and `read_req`: treated as a write. The read is dropped.
- WAIT: the counter increments each cycle. When counter == WAIT_CYCLES-1, go to ACCESS. WAIT therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS, write: RAM[addr[log2(MEM_DEPTH)-1:0]] ← latched data. The write is suppressed if `addr_err`.
- ACCESS, read: `rd_data` ← RAM word, or 0 if `addr_err`.
- ACCESS, both cases: `module_dv` ← 1, then go to DONE.
- DONE: `module_dv` ← 0, `busy` ← 0, then go to IDLE.
- `rd_data` is unchanged by writes.
- Requests arriving in WAIT, ACCESS or DONE are ignored: not queued, no `module_dv`.
- Latched address and data are used, so input changes after acceptance have no effect.
- Reset values:
  - `rd_data`=0, `module_dv`=0, `busy`=0, `addr_err`=0.
  - State is IDLE and the counter is 0.
  - RAM contents are NOT reset.
- Reset mid-operation (in any state): return to IDLE with no `module_dv` pulse. A pending write is abandoned: the RAM is not written unless ACCESS had already completed.
- Out-of-range addresses still complete with `module_dv`, so the slave never hangs.

## Timing
- Edge E0 samples the request.
- `busy` is visible from the cycle after E0.
- `module_dv` is high for exactly one cycle, beginning after edge E(WAIT_CYCLES+1). `rd_data` is valid in that same cycle.
- `busy` falls after edge E(WAIT_CYCLES+2). The next request can be sampled at E(WAIT_CYCLES+3) or later.
- With WAIT_CYCLES=0, `module_dv` is high in the cycle after E1.
- Request-to-request throughput is WAIT_CYCLES+3 cycles.
- RAM read is synchronous, with one-cycle registered output at the ACCESS edge.

## Test plan
- Write then read, WAIT_CYCLES=3:
  - `write_en` with addr=0x010, data=0x5A at E0 -> `module_dv` high only after E4, `busy` falls after E5.
  - `read_req` addr=0x010 at E6 -> `module_dv` after E10 with `rd_data`=0x5A, `addr_err`=0.
- WAIT_CYCLES=0: write 0xC3 to addr 0xFFF, then read it back -> each `module_dv` appears 1 cycle after acceptance, `rd_data`=0xC3.
- Out of range: `read_req` addr=0x7FFF -> `module_dv` pulses, `rd_data`=0x00, `addr_err`=1.
  - A following write to 0x7FFF -> no RAM word changes (spot-check 0xFFF is unchanged).
- Simultaneous and overlapping requests:
  - `write_en`=`read_req`=1, addr=0x020, data=0x11 -> treated as a write, and a read of 0x020 returns 0x11.
  - A second `read_req` during WAIT -> ignored, exactly one `module_dv`.
- Reset mid-WAIT:
  - Write 0x77 to 0x030 (previously holding 0x11); assert `rstn`=0 at E2 -> `busy`=0, `module_dv` never pulses.
  - After release, read 0x030 -> 0x11.
- Reset values: hold `rstn`=0 for 2 cycles with random inputs -> `rd_data`=0, `module_dv`=0, `busy`=0, `addr_err`=0.
